i2s_channel_router: RTL and testbench

- Parametrised successor to the two-channel I2S selector/XOR block.
- Accepts N_CH I2S serial data lines that share one bit clock (sck) and one word select (ws).
- Routes them to one serial output in one of four modes: pass-through, XOR-mix, left/right swap, mute.
- Also deserialises the selected channel into parallel words with per-side parity.
- Sits between the chip I/O pins and the downstream serial/parallel consumers.

---
 rtl/i2s_channel_router_pkg.sv | 14 +
 rtl/i2s_channel_router_if.sv | 31 +++
 rtl/i2s_frame_sync.sv | 48 ++++
 rtl/i2s_channel_router.sv | 138 +++++++++++++
 tb/tb_i2s_channel_router.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/i2s_channel_router_pkg.sv
// Shared types for the I2S channel router and related I2S blocks.
package i2s_router_pkg;

   typedef enum logic [1:0] {
      MODE_PASS = 2'd0,
      MODE_XOR  = 2'd1,
      MODE_SWAP = 2'd2,
      MODE_MUTE = 2'd3
   } mode_t;

   localparam logic SIDE_LEFT  = 1'b0;
   localparam logic SIDE_RIGHT = 1'b1;

endpackage

// File: rtl/i2s_channel_router_if.sv
// Pin-side and consumer-side signal bundle of the I2S channel router.
interface i2s_channel_router_if #(
   parameter int unsigned N_CH   = 4,
   parameter int unsigned WORD_W = 16,
   parameter int unsigned SEL_W  = $clog2(N_CH)
);

   logic              ws;
   logic [N_CH-1:0]   sd_in;
   logic [SEL_W-1:0]  ch_sel;
   logic [1:0]        mode;
   logic              sd_out;
   logic              wsd;
   logic              wsp;
   logic [WORD_W-1:0] word_out;
   logic              word_side;
   logic              word_valid;
   logic              parity_left;
   logic              parity_right;

   modport master (
      output ws, sd_in, ch_sel, mode,
      input  sd_out, wsd, wsp, word_out, word_side, word_valid, parity_left, parity_right
   );

   modport slave (
      input  ws, sd_in, ch_sel, mode,
      output sd_out, wsd, wsp, word_out, word_side, word_valid, parity_left, parity_right
   );

endinterface

// File: rtl/i2s_frame_sync.sv
// I2S word-select pipeline: delayed ws, one-sck change pulse and a saturating
// per-half-frame bit counter that restarts at 1 on the MSB edge.
module i2s_frame_sync #(
   parameter int unsigned WORD_W = 16,
   parameter int unsigned CNT_W  = $clog2(WORD_W + 1)
) (
   input  logic             sck,
   input  logic             rst,
   input  logic             ws_i,
   output logic             wsd_o,
   output logic             wsp_o,
   output logic [CNT_W-1:0] bit_cnt_o
);

   localparam logic [CNT_W-1:0] CntMax = CNT_W'(WORD_W);

   logic             ws_d1_q, ws_d2_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             wsp;

   assign wsp = ws_d1_q ^ ws_d2_q;

   always_comb begin
      cnt_d = cnt_q;
      if (wsp) begin
         cnt_d = CNT_W'(1);
      end else if (cnt_q < CntMax) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge sck) begin
      if (rst) begin
         ws_d1_q <= 1'b0;
         ws_d2_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         ws_d1_q <= ws_i;
         ws_d2_q <= ws_d1_q;
         cnt_q   <= cnt_d;
      end
   end

   assign wsd_o     = ws_d1_q;
   assign wsp_o     = wsp;
   assign bit_cnt_o = cnt_q;

endmodule

// File: rtl/i2s_channel_router.sv
// Routes N_CH I2S data lines to one serial output (pass/xor/swap/mute) and
// deserialises the selected channel into words with per-side parity.
module i2s_channel_router
   import i2s_router_pkg::*;
#(
   parameter int unsigned N_CH   = 4,
   parameter int unsigned WORD_W = 16,
   parameter int unsigned SEL_W  = $clog2(N_CH)
) (
   input logic                 sck,
   input logic                 rst,
   i2s_channel_router_if.slave bus
);

   localparam int unsigned CNT_W = $clog2(WORD_W + 1);

   logic             wsd, wsp;
   logic [CNT_W-1:0] bit_cnt;

   i2s_frame_sync #(
      .WORD_W (WORD_W),
      .CNT_W  (CNT_W)
   ) u_frame_sync (
      .sck       (sck),
      .rst       (rst),
      .ws_i      (bus.ws),
      .wsd_o     (wsd),
      .wsp_o     (wsp),
      .bit_cnt_o (bit_cnt)
   );

   logic [SEL_W-1:0]  sel_q, sel_d, eff_sel;
   mode_t             mode_q, mode_d, eff_mode;
   logic              first_q, first_d;
   logic [WORD_W-1:0] capture_q, capture_d;
   logic [WORD_W-1:0] swap_q, swap_d;
   logic [WORD_W-1:0] word_out_q, word_out_d;
   logic              sd_out_q, sd_out_d;
   logic              word_side_q, word_side_d;
   logic              word_valid_q, word_valid_d;
   logic              parity_left_q, parity_left_d;
   logic              parity_right_q, parity_right_d;
   logic              sel_bit, swap_bit, ended_side;

   always_comb begin
      // Selection and mode switch on the MSB edge itself, so the new half-frame is routed fully.
      eff_sel        = wsp ? bus.ch_sel : sel_q;
      eff_mode       = wsp ? mode_t'(bus.mode) : mode_q;
      sel_bit        = bus.sd_in[eff_sel];
      ended_side     = ~wsd;
      sel_d          = sel_q;
      mode_d         = mode_q;
      first_d        = first_q;
      capture_d      = capture_q;
      swap_d         = swap_q << 1;
      swap_bit       = swap_q[WORD_W-1];
      word_out_d     = word_out_q;
      word_side_d    = word_side_q;
      word_valid_d   = 1'b0;
      parity_left_d  = parity_left_q;
      parity_right_d = parity_right_q;
      sd_out_d       = 1'b0;

      if (wsp) begin
         sel_d                 = bus.ch_sel;
         mode_d                = eff_mode;
         first_d               = 1'b0;
         capture_d             = '0;
         capture_d[WORD_W-1]   = sel_bit;
         swap_d                = '0;
         swap_bit              = 1'b0;
         if (!first_q) begin
            word_out_d   = capture_q;
            word_side_d  = ended_side;
            word_valid_d = 1'b1;
            swap_d       = capture_q << 1;
            swap_bit     = capture_q[WORD_W-1];
            if (ended_side == SIDE_LEFT) begin
               parity_left_d = ^capture_q;
            end else begin
               parity_right_d = ^capture_q;
            end
         end
      end else begin
         // A saturated count matches no bit position, so long half-frames are ignored.
         for (int i = 0; i < int'(WORD_W); i++) begin
            if (int'(bit_cnt) == int'(WORD_W) - 1 - i) begin
               capture_d[i] = sel_bit;
            end
         end
      end

      unique case (eff_mode)
         MODE_PASS: sd_out_d = sel_bit;
         MODE_XOR:  sd_out_d = ^bus.sd_in;
         MODE_SWAP: sd_out_d = swap_bit;
         MODE_MUTE: sd_out_d = 1'b0;
      endcase
   end

   always_ff @(posedge sck) begin
      if (rst) begin
         sel_q          <= '0;
         mode_q         <= MODE_PASS;
         first_q        <= 1'b1;
         capture_q      <= '0;
         swap_q         <= '0;
         word_out_q     <= '0;
         sd_out_q       <= 1'b0;
         word_side_q    <= 1'b0;
         word_valid_q   <= 1'b0;
         parity_left_q  <= 1'b0;
         parity_right_q <= 1'b0;
      end else begin
         sel_q          <= sel_d;
         mode_q         <= mode_d;
         first_q        <= first_d;
         capture_q      <= capture_d;
         swap_q         <= swap_d;
         word_out_q     <= word_out_d;
         sd_out_q       <= sd_out_d;
         word_side_q    <= word_side_d;
         word_valid_q   <= word_valid_d;
         parity_left_q  <= parity_left_d;
         parity_right_q <= parity_right_d;
      end
   end

   assign bus.sd_out       = sd_out_q;
   assign bus.wsd          = wsd;
   assign bus.wsp          = wsp;
   assign bus.word_out     = word_out_q;
   assign bus.word_side    = word_side_q;
   assign bus.word_valid   = word_valid_q;
   assign bus.parity_left  = parity_left_q;
   assign bus.parity_right = parity_right_q;

endmodule

// File: tb/tb_i2s_channel_router.sv
// Bench for i2s_channel_router: table-driven frame scenarios, hand-written corner
// sequences and random frames, all compared per cycle against a queue-based model.
module tb_i2s_channel_router;
   import i2s_router_pkg::*;

   localparam int N_CH   = 4;
   localparam int WORD_W = 16;

   typedef logic [N_CH-1:0][31:0] lanes_t;
   typedef struct {
      logic [1:0]  mode;
      logic [1:0]  sel;
      int          len;
      lanes_t      dl;
      lanes_t      dr;
      logic [15:0] wl, wr, sl, sr;
   } vec_t;

   logic sck = 1'b0;
   logic rst = 1'b1;
   always #5 sck = ~sck;

   i2s_channel_router_if #(.N_CH(N_CH), .WORD_W(WORD_W)) bus_if ();

   i2s_channel_router #(.N_CH(N_CH), .WORD_W(WORD_W)) dut (
      .sck (sck),
      .rst (rst),
      .bus (bus_if)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic              sdo_log[$], vld_log[$], wsp_log[$], wsd_log[$], pl_log[$], pr_log[$];
   logic [WORD_W-1:0] wrd_log[$];
   int                hs[$];
   logic [N_CH-1:0]   carry_bits;

   // Reference model: a half-frame is the queue of bits seen since the last ws change.
   logic              m_p1, m_p2, m_first;
   logic [1:0]        m_sel, m_mode;
   logic              m_cur[$], m_play[$];
   logic              e_sd, e_wsd, e_wsp, e_valid, e_side, e_pl, e_pr;
   logic [WORD_W-1:0] e_word;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic model_step(input logic r, input logic w, input logic [N_CH-1:0] sd,
                             input logic [1:0] cs, input logic [1:0] md);
      logic              out_bit;
      logic              side;
      logic [WORD_W-1:0] word;
      if (r) begin
         m_p1 = 1'b0; m_p2 = 1'b0; m_first = 1'b1; m_sel = 2'd0; m_mode = MODE_PASS;
         m_cur.delete(); m_play.delete();
         e_sd = 1'b0; e_valid = 1'b0; e_side = 1'b0; e_pl = 1'b0; e_pr = 1'b0; e_word = '0;
         e_wsd = 1'b0; e_wsp = 1'b0;
         return;
      end
      e_valid = 1'b0;
      if (m_p1 != m_p2) begin
         m_sel  = cs;
         m_mode = md;
         if (m_first) begin
            m_first = 1'b0;
            m_play.delete();
         end else begin
            word = '0;
            foreach (m_cur[i]) word[WORD_W-1-i] = m_cur[i];
            side    = ~m_p1;
            e_word  = word;
            e_side  = side;
            e_valid = 1'b1;
            if (side == SIDE_RIGHT) e_pr = ^word;
            else e_pl = ^word;
            m_play = m_cur;
         end
         m_cur.delete();
         m_cur.push_back(sd[m_sel]);
      end else if (m_cur.size() < WORD_W) begin
         m_cur.push_back(sd[m_sel]);
      end
      out_bit = (m_play.size() > 0) ? m_play.pop_front() : 1'b0;
      case (m_mode)
         MODE_PASS: e_sd = sd[m_sel];
         MODE_XOR:  e_sd = ($countones(sd) % 2) == 1;
         MODE_SWAP: e_sd = out_bit;
         default:   e_sd = 1'b0;
      endcase
      m_p2  = m_p1;
      m_p1  = w;
      e_wsd = m_p1;
      e_wsp = m_p1 ^ m_p2;
   endtask

   task automatic cycle();
      @(posedge sck);
      model_step(rst, bus_if.ws, bus_if.sd_in, bus_if.ch_sel, bus_if.mode);
      @(negedge sck);
      check("sd_out", 32'(bus_if.sd_out), 32'(e_sd));
      check("wsd", 32'(bus_if.wsd), 32'(e_wsd));
      check("wsp", 32'(bus_if.wsp), 32'(e_wsp));
      check("word_valid", 32'(bus_if.word_valid), 32'(e_valid));
      check("word_side", 32'(bus_if.word_side), 32'(e_side));
      check("word_out", 32'(bus_if.word_out), 32'(e_word));
      check("parity_left", 32'(bus_if.parity_left), 32'(e_pl));
      check("parity_right", 32'(bus_if.parity_right), 32'(e_pr));
      sdo_log.push_back(bus_if.sd_out);
      vld_log.push_back(bus_if.word_valid);
      wsp_log.push_back(bus_if.wsp);
      wsd_log.push_back(bus_if.wsd);
      pl_log.push_back(bus_if.parity_left);
      pr_log.push_back(bus_if.parity_right);
      wrd_log.push_back(bus_if.word_out);
      cyc++;
   endtask

   // Word bits go out MSB-first on the edges after the ws change; the last bit lands on
   // the next half-frame's first edge.
   task automatic run_half(input logic side, input int len, input lanes_t d, input int chg_at,
                           input logic [1:0] chg_sel, input logic [1:0] chg_mode,
                           input int rst_at);
      hs.push_back(cyc);
      for (int j = 0; j < len; j++) begin
         if (j == chg_at) begin
            bus_if.ch_sel = chg_sel;
            bus_if.mode   = chg_mode;
         end
         rst       = (j == rst_at);
         bus_if.ws = side;
         for (int l = 0; l < N_CH; l++) begin
            if (j == 0) bus_if.sd_in[l] = carry_bits[l];
            else if (j <= 32) bus_if.sd_in[l] = d[l][32-j];
            else bus_if.sd_in[l] = 1'b0;
         end
         cycle();
      end
      rst = 1'b0;
      for (int l = 0; l < N_CH; l++) carry_bits[l] = (len <= 32) ? d[l][32-len] : 1'b0;
   endtask

   task automatic do_reset(input logic [1:0] md, input logic [1:0] sel);
      rst           = 1'b1;
      bus_if.ws     = 1'b0;
      bus_if.sd_in  = '0;
      bus_if.ch_sel = sel;
      bus_if.mode   = md;
      carry_bits    = '0;
      cycle();
      cycle();
      rst = 1'b0;
      hs.delete();
   endtask

   function automatic logic [31:0] ser(input int start, input int n);
      logic [31:0] v = '0;
      for (int k = 0; k < n; k++) v = {v[30:0], sdo_log[start+1+k]};
      return v;
   endfunction

   function automatic lanes_t mkl(input logic [31:0] a, b, c, e);
      lanes_t x;
      x[0] = a; x[1] = b; x[2] = c; x[3] = e;
      return x;
   endfunction

   function automatic vec_t mkv(input logic [1:0] m, input logic [1:0] s, input int len,
                                input lanes_t dl, input lanes_t dr,
                                input logic [15:0] wl, wr, sl, sr);
      vec_t v;
      v.mode = m; v.sel = s; v.len = len; v.dl = dl; v.dr = dr;
      v.wl = wl; v.wr = wr; v.sl = sl; v.sr = sr;
      return v;
   endfunction

   vec_t vt[6];

   initial begin
      lanes_t zl, ld, rd;
      int     n;
      logic   side;
      zl = '0;
      vt[0] = mkv(MODE_PASS, 2'd2, 20, mkl(32'hFFFFFFFF, 32'h0, 32'hA5C30000, 32'h0),
                  mkl(32'hFFFFFFFF, 32'h0, 32'hA5C30000, 32'h0),
                  16'hA5C3, 16'hA5C3, 16'hA5C3, 16'hA5C3);
      vt[1] = mkv(MODE_XOR, 2'd0, 20,
                  mkl(32'hFFFF0000, 32'h00FF0000, 32'h0F0F0000, 32'h0),
                  mkl(32'hFFFF0000, 32'h00FF0000, 32'h0F0F0000, 32'h0),
                  16'hFFFF, 16'hFFFF, 16'hF00F, 16'hF00F);
      vt[2] = mkv(MODE_SWAP, 2'd0, 20, mkl(32'h12340000, 32'hFFFF0000, 32'h0, 32'h0),
                  mkl(32'hBEEF0000, 32'hFFFF0000, 32'h0, 32'h0),
                  16'h1234, 16'hBEEF, 16'hBEEF, 16'h1234);
      vt[3] = mkv(MODE_PASS, 2'd1, 10, mkl(32'hFFFFFFFF, 32'hB3800000, 32'h0, 32'h0),
                  mkl(32'hFFFFFFFF, 32'hB3800000, 32'h0, 32'h0),
                  16'hB380, 16'hB380, 16'hB380, 16'hB380);
      vt[4] = mkv(MODE_SWAP, 2'd3, 24, mkl(32'h0, 32'h0, 32'h0, 32'h1234FF00),
                  mkl(32'h0, 32'h0, 32'h0, 32'hBEEFFF00),
                  16'h1234, 16'hBEEF, 16'hBEEF, 16'h1234);
      vt[5] = mkv(MODE_MUTE, 2'd0, 20, mkl(32'h5A5A0000, 32'h0, 32'h0, 32'h0),
                  mkl(32'h0F0F0000, 32'h0, 32'h0, 32'h0),
                  16'h5A5A, 16'h0F0F, 16'h0000, 16'h0000);

      do_reset(MODE_PASS, 2'd0);
      check("reset_word_out", 32'(bus_if.word_out), 32'h0);
      check("reset_valid", 32'(bus_if.word_valid), 32'h0);
      check("reset_sd_out", 32'(bus_if.sd_out), 32'h0);

      for (int v = 0; v < 6; v++) begin
         do_reset(vt[v].mode, vt[v].sel);
         for (int h = 0; h < 7; h++) begin
            side = (h % 2 == 0) ? SIDE_RIGHT : SIDE_LEFT;
            run_half(side, vt[v].len, (side == SIDE_RIGHT) ? vt[v].dr : vt[v].dl, -1, 2'd0,
                     2'd0, -1);
         end
         check("tbl_first_suppressed", 32'(vld_log[hs[0]+1]), 32'h0);
         for (int h = 1; h < 7; h++) begin
            check("tbl_valid", 32'(vld_log[hs[h]+1]), 32'h1);
            check("tbl_word", 32'(wrd_log[hs[h]+1]), 32'((h % 2 == 1) ? vt[v].wr : vt[v].wl));
         end
         n = (vt[v].len < WORD_W) ? vt[v].len : WORD_W;
         for (int h = 1; h < 6; h++) begin
            check("tbl_serial", ser(hs[h], n),
                  32'(((h % 2 == 1) ? vt[v].sl : vt[v].sr) >> (WORD_W - n)));
         end
         if (vt[v].mode == MODE_SWAP) begin
            check("swap_first_half_zero", ser(hs[0], n), 32'h0);
            if (vt[v].len > WORD_W) begin
               check("swap_tail_zero", ser(hs[2] + WORD_W, vt[v].len - WORD_W), 32'h0);
            end
         end
         check("tbl_parity_left", 32'(bus_if.parity_left), 32'(^vt[v].wl));
         check("tbl_parity_right", 32'(bus_if.parity_right), 32'(^vt[v].wr));
      end

      // Mid-half-frame sel/mode change only takes hold at the next wsp edge.
      ld = mkl(32'hAAAA0000, 32'h0, 32'h0, 32'h55550000);
      do_reset(MODE_PASS, 2'd0);
      run_half(SIDE_RIGHT, 20, ld, -1, 2'd0, 2'd0, -1);
      run_half(SIDE_LEFT, 20, ld, -1, 2'd0, 2'd0, -1);
      run_half(SIDE_RIGHT, 20, ld, 8, 2'd3, MODE_MUTE, -1);
      run_half(SIDE_LEFT, 20, ld, -1, 2'd0, 2'd0, -1);
      run_half(SIDE_RIGHT, 20, ld, -1, 2'd0, 2'd0, -1);
      check("chg_serial_before", ser(hs[2], WORD_W), 32'hAAAA);
      check("chg_word_before", 32'(wrd_log[hs[3]+1]), 32'hAAAA);
      check("chg_serial_muted", ser(hs[3], WORD_W), 32'h0);
      check("chg_word_after", 32'(wrd_log[hs[4]+1]), 32'h5555);

      // One-cycle reset inside a left half-frame.
      ld = mkl(32'hC0DE0000, 32'h0, 32'h0, 32'h0);
      do_reset(MODE_PASS, 2'd0);
      run_half(SIDE_RIGHT, 20, ld, -1, 2'd0, 2'd0, -1);
      run_half(SIDE_LEFT, 20, ld, -1, 2'd0, 2'd0, -1);
      run_half(SIDE_RIGHT, 20, ld, -1, 2'd0, 2'd0, -1);
      run_half(SIDE_LEFT, 20, ld, -1, 2'd0, 2'd0, 7);
      run_half(SIDE_RIGHT, 20, ld, -1, 2'd0, 2'd0, -1);
      run_half(SIDE_LEFT, 20, ld, -1, 2'd0, 2'd0, -1);
      check("rst_word_cleared", 32'(wrd_log[hs[3]+7]), 32'h0);
      check("rst_sd_cleared", 32'(sdo_log[hs[3]+7]), 32'h0);
      check("rst_wsd_cleared", 32'(wsd_log[hs[3]+7]), 32'h0);
      check("rst_parity_cleared", 32'({pl_log[hs[3]+7], pr_log[hs[3]+7]}), 32'h0);
      check("rst_first_wsp_no_valid", 32'(vld_log[hs[4]+1]), 32'h0);
      check("rst_resume_valid", 32'(vld_log[hs[5]+1]), 32'h1);
      check("rst_resume_word", 32'(wrd_log[hs[5]+1]), 32'hC0DE);

      // ws toggling every sck: every edge is a wsp edge and reports a 1-bit word.
      ld = mkl(32'h0, 32'hF0000000, 32'h0, 32'h0);
      rd = mkl(32'h0, 32'h70000000, 32'h0, 32'h0);
      do_reset(MODE_PASS, 2'd1);
      run_half(SIDE_RIGHT, 20, rd, -1, 2'd1, 2'd0, -1);
      run_half(SIDE_LEFT, 20, ld, -1, 2'd1, 2'd0, -1);
      for (int h = 0; h < 8; h++) begin
         run_half((h % 2 == 0) ? SIDE_RIGHT : SIDE_LEFT, 1, (h % 2 == 0) ? rd : ld, -1, 2'd1,
                  2'd0, -1);
      end
      for (int h = 3; h < 10; h++) begin
         check("toggle_wsp", 32'(wsp_log[hs[h]]), 32'h1);
         check("toggle_valid", 32'(vld_log[hs[h]]), 32'h1);
      end

      // Random frames, lengths, mode/sel changes and occasional resets.
      do_reset(MODE_PASS, 2'd0);
      for (int h = 0; h < 300; h++) begin
         int len, chg_at, rst_at;
         for (int l = 0; l < N_CH; l++) ld[l] = $urandom;
         len    = $urandom_range(1, 26);
         chg_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len - 1) : -1;
         rst_at = ($urandom_range(0, 24) == 0) ? $urandom_range(0, len - 1) : -1;
         run_half((h % 2 == 0) ? SIDE_RIGHT : SIDE_LEFT, len, ld, chg_at,
                  2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), rst_at);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
